// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge
//   Turns a handshaked SRAM-like CPU port into AXI4 single-beat
//   transactions, with at most one transaction in flight at a time.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   cpu_req/wr/size/addr/wstrb/wdata  CPU request side
//   cpu_addr_ok                    request accepted this cycle (combinational)
//   cpu_data_ok                    one-cycle pulse: read data valid / write done
//   cpu_rdata                      registered read data
//   cpu_bus_err                    only with SRAM_AXI_BUS_ERR_EN: response was
//                                  SLVERR/DECERR, aligned with cpu_data_ok
//   ar*/r*/aw*/w*/b*               AXI4 master channels (single beat, INCR)
//
// Build option
//   SRAM_AXI_BUS_ERR_EN            adds cpu_bus_err and inspects rresp/bresp.

module sram_axi_bridge #(
  parameter logic [3:0]  AXI_ID = 4'd0,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [1:0]        cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [3:0]        cpu_wstrb,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_addr_ok,
  output logic              cpu_data_ok,
  output logic [31:0]       cpu_rdata,
`ifdef SRAM_AXI_BUS_ERR_EN
  output logic              cpu_bus_err,
`endif
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [3:0]        awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [3:0]        bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       wdata_q;
  logic              aw_done;
  logic              w_done;

  logic accept;
  logic aw_hs;
  logic w_hs;
  logic aw_fin;
  logic w_fin;

  assign cpu_addr_ok = (state == IDLE) && cpu_req;
  assign accept      = cpu_req && cpu_addr_ok;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  // A channel counts as finished if it completed earlier or completes now.
  assign aw_fin = aw_done || aw_hs;
  assign w_fin  = w_done || w_hs;

  assign arid    = AXI_ID;
  assign awid    = AXI_ID;
  assign arlen   = '0;
  assign awlen   = '0;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign araddr  = addr_q;
  assign awaddr  = addr_q;
  assign arsize  = {1'b0, size_q};
  assign awsize  = {1'b0, size_q};
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = wvalid;

  logic unused_inputs;
`ifdef SRAM_AXI_BUS_ERR_EN
  assign unused_inputs = ^{rid, rlast, bid, rresp[0], bresp[0]};
`else
  assign unused_inputs = ^{rid, rlast, bid, rresp, bresp};
`endif

  // Transfer direction is carried by the state itself, so no separate
  // direction register is kept after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      cpu_data_ok <= 1'b0;
      cpu_rdata   <= '0;
`ifdef SRAM_AXI_BUS_ERR_EN
      cpu_bus_err <= 1'b0;
`endif
    end else begin
      cpu_data_ok <= 1'b0;
`ifdef SRAM_AXI_BUS_ERR_EN
      cpu_bus_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= cpu_addr;
            size_q  <= (cpu_size == 2'd3) ? 2'd2 : cpu_size;
            wstrb_q <= cpu_wstrb;
            wdata_q <= cpu_wdata;
            if (cpu_wr) begin
              state   <= WR_REQ;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
            end else begin
              state   <= RD_ADDR;
              arvalid <= 1'b1;
            end
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            rready      <= 1'b0;
            cpu_rdata   <= rdata;
            cpu_data_ok <= 1'b1;
`ifdef SRAM_AXI_BUS_ERR_EN
            cpu_bus_err <= rresp[1];
`endif
            state       <= IDLE;
          end
        end
        WR_REQ: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            bready <= 1'b1;
            state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready      <= 1'b0;
            cpu_data_ok <= 1'b1;
`ifdef SRAM_AXI_BUS_ERR_EN
            cpu_bus_err <= bresp[1];
`endif
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb_sram_axi_bridge
//   Drives the CPU port with directed and random transactions against an
//   AXI slave memory with random handshake timing; read results, AXI
//   payloads and latencies are compared to a word-addressed reference memory.

module tb_sram_axi_bridge;

  localparam int unsigned ADDR_W = 32;
  localparam logic [3:0]  ID     = 4'd5;

  logic clk;
  logic rst;
  logic cpu_req, cpu_wr, cpu_addr_ok, cpu_data_ok;
  logic [1:0] cpu_size;
  logic [ADDR_W-1:0] cpu_addr;
  logic [3:0] cpu_wstrb;
  logic [31:0] cpu_wdata, cpu_rdata;
`ifdef SRAM_AXI_BUS_ERR_EN
  logic cpu_bus_err;
`endif
  logic [3:0] arid, awid, rid, bid;
  logic [ADDR_W-1:0] araddr, awaddr;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst, rresp, bresp;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [31:0] rdata, wdata;
  logic [3:0] wstrb;

  sram_axi_bridge #(.AXI_ID(ID), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wstrb(cpu_wstrb), .cpu_wdata(cpu_wdata),
    .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
`ifdef SRAM_AXI_BUS_ERR_EN
    .cpu_bus_err(cpu_bus_err),
`endif
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory content before any write: a fixed pattern per word address.
  function automatic logic [31:0] init_word(input int unsigned w);
    return (w * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Reference memory, updated when the CPU issues a write.
  logic [31:0] ref_mem [int unsigned];
  function automatic logic [31:0] ref_read(input logic [31:0] a);
    int unsigned w;
    w = a >> 2;
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  // Expected payload of the transaction in flight.
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_wstrb;
  logic [1:0]  cur_size_exp;

  // Slave configuration set by the stimulus process.
  bit fast = 0;
  int aw_stall = 0;
  int force_resp = -1;

  // Slave state.
  logic [31:0] smem [int unsigned];
  int unsigned ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
  bit ar_fire, r_fire, aw_fire, w_fire, b_fire;
  bit ar_wait, aw_wait, w_wait;
  bit rd_pend, aw_got, w_got;
  int r_wait, aw_vcnt;
  int unsigned rd_word, aw_word;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic [31:0] ar_addr_q, aw_addr_q;
  logic last_err;

  initial begin
    arready = 0; rvalid = 0; rdata = '0; rresp = '0; rid = '0; rlast = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0; bid = '0;
    {ar_fire, r_fire, aw_fire, w_fire, b_fire} = '0;
    {ar_wait, aw_wait, w_wait, rd_pend, aw_got, w_got} = '0;
    r_wait = 0; aw_vcnt = 0; last_err = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        {ar_fire, r_fire, aw_fire, w_fire, b_fire} = '0;
        {ar_wait, aw_wait, w_wait, rd_pend, aw_got, w_got} = '0;
        aw_vcnt = 0;
      end else begin
        // Handshakes decided last negedge completed at the edge just passed.
        if (r_fire) begin rvalid = 0; rd_pend = 0; end
        if (b_fire) begin bvalid = 0; aw_got = 0; w_got = 0; end
        if (ar_fire) begin
          rd_pend = 1; rd_word = ar_addr_q >> 2;
          r_wait = fast ? 0 : $urandom_range(0, 3);
        end
        if (aw_fire) begin aw_got = 1; aw_word = aw_addr_q >> 2; aw_vcnt = 0; end
        if (w_fire) w_got = 1;

        if (ar_wait) check("ar_hold", 32'(arvalid), 1);
        if (aw_wait) check("aw_hold", 32'(awvalid), 1);
        if (w_wait)  check("w_hold", 32'(wvalid), 1);
        if (bready)  check("bready_after_hs", 32'(awvalid | wvalid), 0);
        if (arvalid) check("ar_aw_excl", 32'(awvalid), 0);

        arready = fast ? 1'b1 : ($urandom_range(0, 2) == 0);
        ar_fire = arvalid && arready;
        if (ar_fire) begin
          ar_cnt++;
          ar_addr_q = araddr;
          check("araddr", araddr, cur_addr);
          check("arsize", 32'(arsize), 32'({1'b0, cur_size_exp}));
          check("arid", 32'(arid), 32'(ID));
          check("arlen_burst", 32'({arlen, arburst}), 32'h1);
        end
        ar_wait = arvalid && !arready;

        if (rd_pend && !rvalid) begin
          if (r_wait == 0) begin
            rvalid = 1;
            rdata  = smem.exists(rd_word) ? smem[rd_word] : init_word(rd_word);
            rresp  = (force_resp >= 0) ? 2'(force_resp) : 2'($urandom_range(0, 3));
          end else r_wait--;
        end
        r_fire = rvalid && rready;
        if (r_fire) last_err = rresp[1];

        if (awvalid) aw_vcnt++;
        awready = fast ? 1'b1 : (aw_stall > 0) ? (aw_vcnt > aw_stall) : ($urandom_range(0, 2) == 0);
        aw_fire = awvalid && awready;
        if (aw_fire) begin
          aw_cnt++;
          aw_addr_q = awaddr;
          check("awaddr", awaddr, cur_addr);
          check("awsize", 32'(awsize), 32'({1'b0, cur_size_exp}));
          check("awid", 32'(awid), 32'(ID));
          check("awlen_burst", 32'({awlen, awburst}), 32'h1);
        end
        aw_wait = awvalid && !awready;

        wready = (fast || aw_stall > 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
        w_fire = wvalid && wready;
        if (w_fire) begin
          w_cnt++;
          w_data_q = wdata; w_strb_q = wstrb;
          check("wdata", wdata, cur_wdata);
          check("wstrb", 32'(wstrb), 32'(cur_wstrb));
          check("wlast", 32'(wlast), 1);
        end
        w_wait = wvalid && !wready;

        if (aw_got && w_got && !bvalid && (fast || aw_stall > 0 || $urandom_range(0, 1) == 1)) begin
          smem[aw_word] = merge(smem.exists(aw_word) ? smem[aw_word] : init_word(aw_word),
                                w_data_q, w_strb_q);
          bvalid = 1;
          bresp  = (force_resp >= 0) ? 2'(force_resp) : 2'($urandom_range(0, 3));
        end
        b_fire = bvalid && bready;
        if (b_fire) last_err = bresp[1];
      end
    end
  end

  // Issues one transaction starting in the current cycle (called at posedge+1).
  // With hold set, cpu_req stays high throughout and the next call must follow
  // immediately, since the bridge accepts it in the completion cycle.
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic [3:0] strb, input logic [31:0] wd,
                        input bit hold, input int exp_lat);
    logic [31:0] exp_rd;
    int unsigned a0, aw0, w0;
    int n;
    cur_addr = addr; cur_wdata = wd; cur_wstrb = strb;
    cur_size_exp = (size == 2'd3) ? 2'd2 : size;
    cpu_req = 1; cpu_wr = wr; cpu_addr = addr; cpu_size = size;
    cpu_wstrb = strb; cpu_wdata = wd;
    exp_rd = '0;
    if (wr) ref_mem[addr >> 2] = merge(ref_read(addr), wd, strb);
    else exp_rd = ref_read(addr);
    a0 = ar_cnt; aw0 = aw_cnt; w0 = w_cnt;
    #1;
    check("addr_ok", 32'(cpu_addr_ok), 1);
    @(posedge clk); #1;
    n = 1;
    if (!hold) cpu_req = 0;
    #1;
    while (!cpu_data_ok && n < 100) begin
      if (hold) check("busy_addr_ok", 32'(cpu_addr_ok), 0);
      @(posedge clk); #2;
      n++;
    end
    if (!cpu_data_ok) begin
      check("data_ok_timeout", 0, 1);
    end else begin
      if (exp_lat > 0) check("latency", 32'(n), 32'(exp_lat));
      if (!wr) check("rdata", cpu_rdata, exp_rd);
      if (hold) check("b2b_addr_ok", 32'(cpu_addr_ok), 1);
      check("ar_count", 32'(ar_cnt - a0), wr ? 0 : 1);
      check("aw_count", 32'(aw_cnt - aw0), wr ? 1 : 0);
      check("w_count", 32'(w_cnt - w0), wr ? 1 : 0);
`ifdef SRAM_AXI_BUS_ERR_EN
      check("bus_err", 32'(cpu_bus_err), 32'(last_err));
`endif
    end
    if (!hold) begin
      @(posedge clk); #2;
      check("data_ok_pulse", 32'(cpu_data_ok), 0);
    end
  endtask

  initial begin
    int txns;
    bit wr, hold;
    rst = 1; cpu_req = 0; cpu_wr = 0; cpu_size = '0; cpu_addr = '0;
    cpu_wstrb = '0; cpu_wdata = '0;
    #12;
    check("rst_arvalid", 32'(arvalid), 0);
    check("rst_awvalid", 32'(awvalid), 0);
    check("rst_wvalid", 32'(wvalid), 0);
    check("rst_rready", 32'(rready), 0);
    check("rst_bready", 32'(bready), 0);
    check("rst_data_ok", 32'(cpu_data_ok), 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_araddr", araddr, 0);
    check("rst_wstrb", 32'(wstrb), 0);
`ifdef SRAM_AXI_BUS_ERR_EN
    check("rst_bus_err", 32'(cpu_bus_err), 0);
`endif
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // Minimum-latency read of boot vector.
    fast = 1;
    smem[32'h1FC0_0000 >> 2] = 32'hDEAD_BEEF;
    ref_mem[32'h1FC0_0000 >> 2] = 32'hDEAD_BEEF;
    do_txn(0, 32'h1FC0_0000, 2'd2, 4'h0, 32'h0, 0, 3);

    // Minimum-latency write, then read back.
    do_txn(1, 32'h8000_0020, 2'd2, 4'hF, 32'hCAFE_F00D, 0, 3);
    do_txn(0, 32'h8000_0020, 2'd2, 4'h0, 32'h0, 0, 3);

    // Write with W accepted at once and AW held off for three cycles.
    fast = 0; aw_stall = 3;
    do_txn(1, 32'h8000_0010, 2'd1, 4'b0011, 32'h1234_5678, 0, 6);
    aw_stall = 0; fast = 1;
    do_txn(0, 32'h8000_0010, 2'd3, 4'h0, 32'h0, 0, 3);

    // Two back-to-back reads with cpu_req held.
    do_txn(0, 32'h8000_0040, 2'd2, 4'h0, 32'h0, 1, 3);
    do_txn(0, 32'h8000_0044, 2'd0, 4'h0, 32'h0, 0, 3);

`ifdef SRAM_AXI_BUS_ERR_EN
    force_resp = 2;
    do_txn(1, 32'h8000_0050, 2'd2, 4'hF, 32'h0BAD_0BAD, 0, 3);
    check("bus_err_forced", 32'(last_err), 1);
    force_resp = 0;
    do_txn(1, 32'h8000_0054, 2'd2, 4'hF, 32'h600D_600D, 0, 3);
    check("bus_err_clear", 32'(last_err), 0);
    force_resp = -1;
`endif

    // Reset while the write address is stalled.
    fast = 0; aw_stall = 1000;
    cur_addr = 32'h8000_0060; cur_wdata = 32'hFFFF_FFFF; cur_wstrb = 4'hF; cur_size_exp = 2'd2;
    cpu_req = 1; cpu_wr = 1; cpu_addr = 32'h8000_0060; cpu_size = 2'd2;
    cpu_wstrb = 4'hF; cpu_wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    cpu_req = 0;
    @(posedge clk); #1;
    check("pre_rst_awvalid", 32'(awvalid), 1);
    #1 rst = 1;
    #1;
    check("rst_mid_awvalid", 32'(awvalid), 0);
    check("rst_mid_wvalid", 32'(wvalid), 0);
    check("rst_mid_bready", 32'(bready), 0);
    check("rst_mid_data_ok", 32'(cpu_data_ok), 0);
    @(posedge clk); #1;
    rst = 0; aw_stall = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post_rst_quiet", 32'({cpu_data_ok, arvalid, awvalid, wvalid}), 0);
    end
    fast = 1;
    do_txn(0, 32'h8000_0060, 2'd2, 4'h0, 32'h0, 0, 3);

    // Random traffic with random slave timing.
    txns = 150;
    for (int i = 0; i < txns; i++) begin
      wr   = $urandom_range(0, 1) == 1;
      hold = (i != txns - 1) && ($urandom_range(0, 3) == 0);
      fast = $urandom_range(0, 3) == 0;
      do_txn(wr, 32'h8000_0000 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3),
             2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom, hold, fast ? 3 : 0);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
Converts one handshaked SRAM-like port from the CPU side into AXI4 single-beat transactions. It sits directly downstream of the CPU top. One instance serves the instruction side and one serves the data side, or a single instance serves both behind an arbiter. At most one transaction is outstanding at a time; the CPU is throttled with addr_ok and data_ok.

Parameters:
AXI_ID, 4'd0, constant value driven on arid and awid.
ADDR_W, 32, address width on the CPU and AXI sides.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
cpu_req  in  1  request valid
cpu_wr  in  1  1 = write, 0 = read
cpu_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as 2
cpu_addr  in  ADDR_W  physical byte address (post-MMU)
cpu_wstrb  in  4  byte enables for writes
cpu_wdata  in  32  write data
cpu_addr_ok  out  1  request accepted this cycle
cpu_data_ok  out  1  one-cycle pulse: read data valid or write complete
cpu_rdata  out  32  registered read data
arid/araddr/arsize/arvalid  out  4/ADDR_W/3/1  AXI read address channel
arlen/arburst  out  8/2  constant 0 / 2'b01
arready  in  1
rdata/rresp/rvalid  in  32/2/1; rid/rlast in 4/1 (ignored)
rready  out  1
awid/awaddr/awsize/awvalid  out  4/ADDR_W/3/1; awlen/awburst out 8/2 constant 0 / 2'b01
awready  in  1
wdata/wstrb/wvalid/wlast  out  32/4/1/1; wlast = wvalid
wready  in  1
bresp/bvalid  in  2/1; bid in 4 (ignored)
bready  out  1

Behaviour:
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- Reset, asynchronous: state = IDLE. All valid/ready outputs, cpu_data_ok and the latched request registers are 0; cpu_rdata = 0.
- Reset mid-transaction drops the transaction silently. The AXI slave shares the same reset.
- cpu_addr_ok is combinational: (state==IDLE) && cpu_req. Acceptance = cpu_req && cpu_addr_ok.
- On acceptance, latch addr, size (3 mapped to 2), wr, wstrb and wdata.
  - Read: go to RD_ADDR. Write: go to WR_REQ.
- RD_ADDR:
  - arvalid = 1; araddr and arsize = {1'b0, size} come from the latched values.
  - On arvalid && arready: go to RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid: cpu_rdata <= rdata, cpu_data_ok <= 1 for exactly the next cycle, state <= IDLE.
- WR_REQ:
  - awvalid and wvalid are raised together on entry. Each deasserts independently after its own handshake, tracked by aw_done/w_done flags.
  - AW and W may complete in either order or in the same cycle.
  - When both are done, go to WR_RESP.
- WR_RESP:
  - bready = 1.
  - On bvalid: cpu_data_ok <= 1 for one cycle, state <= IDLE.
- Because state returns to IDLE in the same cycle cpu_data_ok goes high, a new request may be accepted in that cycle (back-to-back).
- Minimum read latency is 3 cycles (acceptance cycle 0):
  - arvalid high in cycle 1; with arready = 1, the AR handshake completes in cycle 1.
  - rvalid arrives in cycle 2 at the earliest.
  - cpu_data_ok is high in cycle 3.
- Minimum write latency is 3 cycles by the same structure.
- All AXI valid outputs are registered and stay stable until their handshake; the payload never changes while valid is high.
- rresp and bresp are ignored unless the optional feature is enabled.

Optional Feature:
SRAM_AXI_BUS_ERR_EN
- Defined:
  - Adds output cpu_bus_err (1 bit, reset 0).
  - It is high in the same cycle as cpu_data_ok when the completing rresp[1] or bresp[1] was 1 (SLVERR/DECERR).
  - cpu_rdata is still updated from rdata.
- Undefined: the port is absent and responses are never inspected.

Test Plan:
- Read 0x1FC00000, size 2; arready=1; rvalid=1 with rdata=0xDEADBEEF one cycle after the AR handshake -> araddr=0x1FC00000, arsize=3'b010, cpu_data_ok pulse in cycle 3, cpu_rdata=0xDEADBEEF.
- Write 0x80000010, wdata=0x12345678, wstrb=4'b0011; wready=1 immediately, awready delayed 3 cycles -> wvalid drops after cycle 1, awvalid held until the handshake, bready only after both handshakes, cpu_data_ok one cycle after bvalid.
- cpu_req held high for two reads -> second cpu_addr_ok coincides with the first cpu_data_ok; arvalid is never high for two transactions at once.
- cpu_req asserted while in RD_DATA -> cpu_addr_ok=0 and no new arvalid until the return to IDLE.
- rst pulsed high during WR_REQ with awvalid=1 -> awvalid, wvalid and bready go 0 immediately (asynchronously), state IDLE, no cpu_data_ok.
- With SRAM_AXI_BUS_ERR_EN, bresp=2'b10 -> cpu_bus_err=1 together with cpu_data_ok; with bresp=2'b00 -> cpu_bus_err=0.
